// File: rtl/if_stage_queued_pkg.sv
// Shared constants for the queued instruction-fetch stage: word width,
// instruction size and redirect-mode encodings.
package if_stage_queued_pkg;

  localparam int WORD_LEN    = 32;
  localparam int INSTR_BYTES = 4;

  localparam int BR_ABS = 0;
  localparam int BR_REL = 1;

endpackage

// File: rtl/if_stage_queued_fetch_queue.sv
// Synchronous FIFO holding {pc, instr} pairs between fetch and decode.
// Clear wins over push and pop; storage is reset so the head is never X.
module fetch_queue
  import if_stage_queued_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap because DEPTH is a power of 2.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i && !clear_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_stage_queued.sv
// Instruction-fetch stage: PC ownership, single-outstanding fetch to a
// 1-cycle memory, redirect/flush, and a decoupling queue towards decode.
module if_stage_queued
  import if_stage_queued_pkg::*;
#(
  parameter int                            WORD_LEN = if_stage_queued_pkg::WORD_LEN,
  parameter int                            DEPTH    = 4,
  parameter logic [WORD_LEN-1:0]           RESET_PC = '0,
  parameter int                            BR_MODE  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_target,
  input  logic [WORD_LEN-1:0] br_base,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] out_pc,
  output logic [WORD_LEN-1:0] out_instr
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SHIFT = $clog2(INSTR_BYTES);

  logic [WORD_LEN-1:0]   pc_q, pc_d;
  logic [WORD_LEN-1:0]   inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_W-1:0]      count_s;
  logic [2*WORD_LEN-1:0] head_s;
  logic [WORD_LEN-1:0]   target_s;
  logic                  room_s;
  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;

  // Room check counts the outstanding fetch but not a same-cycle pop.
  assign room_s  = ({1'b0, count_s} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W + 1)'(DEPTH);
  assign issue_s = !rst && !br_taken && room_s;
  assign push_s  = inflight_q && !br_taken;
  assign pop_s   = out_valid && out_ready && !br_taken;

  // Redirect target; relative offsets are in instruction words.
  always_comb begin
    target_s = br_target;
    if (BR_MODE == BR_REL) begin
      target_s = br_base + (br_target << SHIFT);
    end else begin
      target_s = br_target;
    end
  end

  // PC and in-flight tracking next-state; redirect overrides issue.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (br_taken) begin
      pc_d       = target_s;
      inflight_d = 1'b0;
    end else if (issue_s) begin
      pc_d          = pc_q + WORD_LEN'(INSTR_BYTES);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end else begin
      pc_d       = pc_q;
      inflight_d = 1'b0;
    end
  end

  // PC and in-flight registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue #(
    .WIDTH (2 * WORD_LEN),
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (br_taken),
    .push_i      (push_s),
    .push_data_i ({inflight_pc_q, imem_rdata}),
    .pop_i       (pop_s),
    .count_o     (count_s),
    .head_o      (head_s)
  );

  assign imem_req  = issue_s;
  assign imem_addr = pc_q;
  assign out_valid = (count_s != '0);
  assign out_pc    = head_s[2*WORD_LEN-1:WORD_LEN];
  assign out_instr = head_s[WORD_LEN-1:0];

endmodule

// File: tb/tb_if_stage_queued.sv
// Directed bench for if_stage_queued: a scoreboard of expected {pc, instr}
// checked on every decode handshake, plus cycle-exact timing checks.
module tb_if_stage_queued;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] br_base;
  logic        out_ready;

  logic        req0, valid0, req1, valid1;
  logic [31:0] addr0, rdata0, pc0, instr0;
  logic [31:0] addr1, rdata1, pc1, instr1;

  logic        s_req0, s_valid0, s_req1, s_valid1;
  logic [31:0] s_addr0, s_pc0, s_instr0, s_addr1, s_pc1, s_instr1;

  int          errors = 0;
  int          checks = 0;
  int          hs_cnt = 0;
  logic        saw_200 = 1'b0;
  logic [31:0] exp_q [$];

  if_stage_queued #(.WORD_LEN(32), .DEPTH(4), .RESET_PC(32'h0), .BR_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_target(br_target), .br_base(br_base),
    .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
    .out_valid(valid0), .out_ready(out_ready), .out_pc(pc0), .out_instr(instr0)
  );

  if_stage_queued #(.WORD_LEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .BR_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_target(br_target), .br_base(br_base),
    .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
    .out_valid(valid1), .out_ready(out_ready), .out_pc(pc1), .out_instr(instr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memories: data = addr ^ K one cycle after a request.
  always_ff @(posedge clk) begin
    rdata0 <= req0 ? (addr0 ^ K) : 32'hDEAD_BEEF;
    rdata1 <= req1 ? (addr1 ^ K) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // One cycle: sample at negedge, score a handshake, then let the edge commit.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    s_req0 = req0; s_addr0 = addr0; s_valid0 = valid0; s_pc0 = pc0; s_instr0 = instr0;
    s_req1 = req1; s_addr1 = addr1; s_valid1 = valid1; s_pc1 = pc1; s_instr1 = instr1;
    if (req0 && addr0 == 32'h200) saw_200 = 1'b1;
    if (!rst && !br_taken && valid0 && out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_underflow_pc", pc0, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", pc0, e);
        chk("sb_instr", instr0, e ^ K);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a0 [8];
    logic [31:0] a1 [8];
    int          nreq;

    rst = 1'b1; br_taken = 1'b0; br_target = 32'h0; br_base = 32'h0; out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(s_valid0), 32'h0);
    chk("rst_req", 32'(s_req0), 32'h0);
    chk("rst_pc", s_pc0, 32'h0);
    chk("rst_instr", s_instr0, 32'h0);
    chk("rst_valid1", 32'(s_valid1), 32'h0);

    // Backpressure from reset: exactly DEPTH requests, then stall.
    rst = 1'b0; out_ready = 1'b0;
    sb_load(32'h0, 64);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin
        chk("c0_addr", s_addr0, 32'h0);
        chk("c0_req", 32'(s_req0), 32'h1);
        chk("c0_addr1", s_addr1, 32'hFFFF_FFF8);
      end
      if (i == 1) chk("c1_valid", 32'(s_valid0), 32'h0);
      if (i == 2) chk("c2_valid", 32'(s_valid0), 32'h1);
      if (s_req0 && nreq < 8) begin
        a0[nreq] = s_addr0;
        a1[nreq] = s_addr1;
        nreq++;
      end
    end
    chk("bp_nreq", 32'(nreq), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_addr", a0[i], 32'(4 * i));
      chk("bp_wrap_addr", a1[i], 32'hFFFF_FFF8 + 32'(4 * i));
    end
    chk("bp_req_off", 32'(s_req0), 32'h0);
    chk("bp_head_pc", s_pc0, 32'h0);

    // Release: drain in order at full rate; wrapped PCs on the second instance.
    out_ready = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i < 4) begin
        chk("wrap_valid", 32'(s_valid1), 32'h1);
        chk("wrap_pc", s_pc1, 32'hFFFF_FFF8 + 32'(4 * i));
        chk("wrap_instr", s_instr1, (32'hFFFF_FFF8 + 32'(4 * i)) ^ K);
      end
    end
    chk("throughput", 32'(hs_cnt), 32'd12);

    // Reset pulse mid-stream.
    rst = 1'b1;
    step();
    step();
    chk("mid_rst_valid", 32'(s_valid0), 32'h0);
    chk("mid_rst_req", 32'(s_req0), 32'h0);
    chk("mid_rst_pc", s_pc0, 32'h0);
    chk("mid_rst_instr", s_instr0, 32'h0);

    // Refill to 3 queued + 1 in flight, then redirect with a pop attempted.
    rst = 1'b0; out_ready = 1'b0;
    step();
    chk("resume_addr", s_addr0, 32'h0);
    chk("resume_req", 32'(s_req0), 32'h1);
    step(); step(); step();
    br_taken = 1'b1; br_target = 32'h100; out_ready = 1'b1;
    sb_load(32'h100, 64);
    step();
    chk("br_req_off", 32'(s_req0), 32'h0);
    chk("pre_br_valid", 32'(s_valid0), 32'h1);
    br_taken = 1'b0;
    step();
    chk("br_t1_valid", 32'(s_valid0), 32'h0);
    chk("br_t1_addr", s_addr0, 32'h100);
    chk("br_t1_req", 32'(s_req0), 32'h1);
    step();
    chk("br_t2_valid", 32'(s_valid0), 32'h0);
    step();
    chk("br_t3_valid", 32'(s_valid0), 32'h1);
    chk("br_t3_pc", s_pc0, 32'h100);
    for (int i = 0; i < 6; i++) step();

    // Back-to-back redirects: only the second target is fetched.
    saw_200 = 1'b0;
    br_taken = 1'b1; br_target = 32'h200;
    sb_load(32'h300, 64);
    step();
    chk("bb_req_off0", 32'(s_req0), 32'h0);
    br_target = 32'h300;
    step();
    chk("bb_req_off1", 32'(s_req0), 32'h0);
    br_taken = 1'b0;
    step();
    chk("bb_addr", s_addr0, 32'h300);
    chk("bb_req", 32'(s_req0), 32'h1);
    for (int i = 0; i < 8; i++) step();
    chk("bb_no_first_target", 32'(saw_200), 32'h0);

    // Relative redirect: 0x40 + (-2 << 2) = 0x38 on the relative instance.
    br_taken = 1'b1; br_base = 32'h40; br_target = 32'hFFFF_FFFE;
    sb_load(32'hFFFF_FFFE, 64);
    step();
    br_taken = 1'b0;
    step();
    chk("rel_addr", s_addr1, 32'h38);
    chk("rel_req", 32'(s_req1), 32'h1);
    chk("abs_unaligned_addr", s_addr0, 32'hFFFF_FFFE);
    step();
    step();
    chk("rel_valid", 32'(s_valid1), 32'h1);
    chk("rel_pc", s_pc1, 32'h38);
    chk("rel_instr", s_instr1, 32'h38 ^ K);
    for (int i = 0; i < 6; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
